// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read-side consumer of the UART transmit FIFO. It pops one word at a time
//   from a first-word-fall-through FIFO and sends it as a UART frame: a start
//   bit, WIDTH data bits LSB first, an optional parity bit and one stop bit.
//   Everything runs in the FIFO read clock domain.
//
// Ports
//   CLK        transmit / FIFO read clock
//   RST        asynchronous active-low reset
//   EMPTY      FIFO empty flag (CLK domain)
//   RD_DATA    FIFO head word, valid while EMPTY=0
//   R_INC      FIFO pop, one-cycle pulse during LOAD
//   PAR_EN     1 = append a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   BIT_CYCLES CLK cycles per serial bit (0 behaves as 1)
//   TX_OUT     serial line, idles high
//   BUSY       high from LOAD until the return to IDLE
module fifo_uart_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EMPTY,
  input  logic [WIDTH-1:0] RD_DATA,
  output logic             R_INC,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [5:0]       BIT_CYCLES,
  output logic             TX_OUT,
  output logic             BUSY
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             par_en_q,  par_en_d;
  logic             par_typ_q, par_typ_d;
  logic [5:0]       bit_cyc_q, bit_cyc_d;
  logic [5:0]       cyc_cnt_q, cyc_cnt_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;

  logic             last_cyc;

  // The cycle counter counts down from the latched bit width minus one, so
  // the last cycle of every serial bit is simply cyc_cnt_q == 0.
  assign last_cyc = (cyc_cnt_q == 6'd0);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    bit_cyc_d = bit_cyc_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_idx_d = bit_idx_q;

    case (state_q)
      IDLE: begin
        if (!EMPTY) state_d = LOAD;
      end

      LOAD: begin
        // Word and frame configuration are frozen here for the whole frame.
        data_d    = RD_DATA;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        bit_cyc_d = (BIT_CYCLES == 6'd0) ? 6'd1 : BIT_CYCLES;
        cyc_cnt_d = bit_cyc_d - 6'd1;
        bit_idx_d = '0;
        state_d   = START;
      end

      START: begin
        if (last_cyc) begin
          cyc_cnt_d = bit_cyc_q - 6'd1;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 6'd1;
        end
      end

      DATA: begin
        if (last_cyc) begin
          cyc_cnt_d = bit_cyc_q - 6'd1;
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - 6'd1;
        end
      end

      PARITY: begin
        if (last_cyc) begin
          cyc_cnt_d = bit_cyc_q - 6'd1;
          state_d   = STOP;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 6'd1;
        end
      end

      STOP: begin
        if (last_cyc) begin
          cyc_cnt_d = '0;
          state_d   = EMPTY ? IDLE : LOAD;
        end else begin
          cyc_cnt_d = cyc_cnt_q - 6'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      bit_cyc_q <= '0;
      cyc_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      bit_cyc_q <= bit_cyc_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  always_comb begin
    R_INC  = (state_q == LOAD);
    BUSY   = (state_q != IDLE);
    TX_OUT = 1'b1;
    case (state_q)
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = data_q[bit_idx_q];
      PARITY:  TX_OUT = (^data_q) ^ par_typ_q;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EMPTY;
  logic [7:0] RD_DATA;
  logic       R_INC;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] BIT_CYCLES;
  logic       TX_OUT;
  logic       BUSY;

  always #5 CLK = ~CLK;

  fifo_uart_tx #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EMPTY      (EMPTY),
    .RD_DATA    (RD_DATA),
    .R_INC      (R_INC),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .BIT_CYCLES (BIT_CYCLES),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  int checks   = 0;
  int failures = 0;

  // FIFO stub (first-word-fall-through, pops on the edge that ends R_INC).
  logic [7:0] fifo_q[$];
  bit         pop_req;

  // Expected line waveform: one entry per cycle, {tx, busy, r_inc}.
  logic [2:0] expq[$];
  logic [2:0] cur;
  bit         build_pending;
  logic [7:0] m_word;

  int cap_tx[$];
  int cap_busy[$];
  int cap_rinc[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    EMPTY   = (fifo_q.size() == 0);
    RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Model step at each rising edge: a frame is a list of serial bits, each
  // repeated B times, preceded by one LOAD cycle; config is taken at the
  // edge that ends LOAD.
  task automatic model_edge();
    int   b;
    logic bitsq[$];
    if (!RST) begin
      expq.delete();
      build_pending = 0;
      cur = 3'b100;
    end else begin
      if (build_pending) begin
        b = (BIT_CYCLES == 0) ? 1 : int'(BIT_CYCLES);
        bitsq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitsq.push_back(m_word[i]);
        if (PAR_EN) bitsq.push_back((^m_word) ^ PAR_TYP);
        bitsq.push_back(1'b1);
        foreach (bitsq[k])
          for (int r = 0; r < b; r++) expq.push_back({bitsq[k], 1'b1, 1'b0});
        build_pending = 0;
      end
      if (expq.size() > 0) begin
        cur = expq.pop_front();
      end else if (!EMPTY) begin
        cur = 3'b111;
        m_word = RD_DATA;
        build_pending = 1;
      end else begin
        cur = 3'b100;
      end
    end
  endtask

  task automatic compare();
    chk("tx",   int'(TX_OUT), int'(cur[2]));
    chk("busy", int'(BUSY),   int'(cur[1]));
    chk("rinc", int'(R_INC),  int'(cur[0]));
    cap_tx.push_back(int'(TX_OUT));
    cap_busy.push_back(int'(BUSY));
    cap_rinc.push_back(int'(R_INC));
    pop_req = R_INC;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    if (pop_req) begin
      chk("pop_nonempty", int'(fifo_q.size() > 0), 1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_req = 0;
    end
    refresh();
    @(negedge CLK);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_caps();
    cap_tx.delete();
    cap_busy.delete();
    cap_rinc.delete();
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int at(input int q[$], input int idx);
    if (idx < 0 || idx >= q.size()) return -1;
    return q[idx];
  endfunction

  function automatic int nth_rinc(input int q[$], input int n);
    int c = 0;
    foreach (q[i]) begin
      if (q[i] == 1) begin
        if (c == n) return i;
        c++;
      end
    end
    return -1;
  endfunction

  // Decode WIDTH data bits sampled at offset first + stride*k.
  function automatic int decode(input int q[$], input int first, input int stride);
    int v = 0;
    for (int k = 0; k < 8; k++)
      if (at(q, first + stride * k) == 1) v |= (1 << k);
    return v;
  endfunction

  task automatic wait_rinc();
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (cap_rinc[cap_rinc.size()-1] == 1) found = 1;
    end
    chk("wait_rinc", int'(found), 1);
  endtask

  int l0, l1, l2;
  int v;

  initial begin
    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; BIT_CYCLES = 6'd1;
    pop_req = 0; build_pending = 0; cur = 3'b100; m_word = '0;
    refresh();

    // Reset state and idle with an empty FIFO.
    #1 RST = 1'b0;
    #1;
    chk("rst_tx", int'(TX_OUT), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_rinc", int'(R_INC), 0);
    ticks(3);
    RST = 1'b1;
    clear_caps();
    ticks(50);
    chk("idle_rinc_count", qsum(cap_rinc), 0);
    chk("idle_tx_high", qsum(cap_tx), 50);

    // Single word 0xA5, no parity, one cycle per bit.
    clear_caps();
    push(8'hA5);
    ticks(20);
    l0 = nth_rinc(cap_rinc, 0);
    chk("a5_rinc_count", qsum(cap_rinc), 1);
    chk("a5_busy_cycles", qsum(cap_busy), 11);
    v = 0;
    for (int k = 0; k < 10; k++) if (at(cap_tx, l0 + 1 + k) == 1) v |= (1 << k);
    chk("a5_line_bits", v, 10'h34A);
    chk("a5_after_idle", at(cap_tx, l0 + 11), 1);

    // Parity on 0x07: even gives 1, odd gives 0; frame is 12 cycles.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_caps();
    push(8'h07);
    ticks(20);
    l0 = nth_rinc(cap_rinc, 0);
    chk("par_even_bit", at(cap_tx, l0 + 10), 1);
    chk("par_even_frame", qsum(cap_busy), 12);
    PAR_TYP = 1'b1;
    clear_caps();
    push(8'h07);
    ticks(20);
    l0 = nth_rinc(cap_rinc, 0);
    chk("par_odd_bit", at(cap_tx, l0 + 10), 0);
    chk("par_odd_frame", qsum(cap_busy), 12);

    // Back-to-back frames, 4 cycles per bit, even parity.
    PAR_TYP = 1'b0; BIT_CYCLES = 6'd4;
    clear_caps();
    push(8'h10); push(8'h20); push(8'h30);
    ticks(150);
    l0 = nth_rinc(cap_rinc, 0);
    l1 = nth_rinc(cap_rinc, 1);
    l2 = nth_rinc(cap_rinc, 2);
    chk("b2b_rinc_count", qsum(cap_rinc), 3);
    chk("b2b_spacing_01", l1 - l0, 45);
    chk("b2b_spacing_12", l2 - l1, 45);
    chk("b2b_byte0", decode(cap_tx, l0 + 7, 4), 8'h10);
    chk("b2b_byte1", decode(cap_tx, l1 + 7, 4), 8'h20);
    chk("b2b_byte2", decode(cap_tx, l2 + 7, 4), 8'h30);
    chk("b2b_par0", at(cap_tx, l0 + 39), 1);
    chk("b2b_par1", at(cap_tx, l1 + 39), 1);
    chk("b2b_par2", at(cap_tx, l2 + 39), 0);
    chk("b2b_busy_cycles", qsum(cap_busy), 135);
    chk("b2b_busy_drop", at(cap_busy, l2 + 45), 0);

    // Config isolation: BIT_CYCLES=0 acts as 1; mid-frame changes apply next frame.
    PAR_EN = 1'b0; BIT_CYCLES = 6'd0;
    clear_caps();
    push(8'h5A); push(8'h3C);
    wait_rinc();
    ticks(5);
    PAR_EN = 1'b1; BIT_CYCLES = 6'd3;
    ticks(60);
    l0 = nth_rinc(cap_rinc, 0);
    l1 = nth_rinc(cap_rinc, 1);
    chk("cfg_spacing", l1 - l0, 11);
    chk("cfg_byte0", decode(cap_tx, l0 + 2, 1), 8'h5A);
    chk("cfg_byte1", decode(cap_tx, l1 + 5, 3), 8'h3C);
    chk("cfg_par1", at(cap_tx, l1 + 29), 0);
    chk("cfg_busy_cycles", qsum(cap_busy), 45);

    // Reset during data bit 3.
    PAR_EN = 1'b0; BIT_CYCLES = 6'd1;
    clear_caps();
    push(8'h00);
    wait_rinc();
    ticks(5);
    chk("pre_rst_tx", int'(TX_OUT), 0);
    RST = 1'b0;
    #1;
    chk("mid_rst_tx", int'(TX_OUT), 1);
    chk("mid_rst_busy", int'(BUSY), 0);
    chk("mid_rst_rinc", int'(R_INC), 0);
    pop_req = 0;
    ticks(3);
    RST = 1'b1;
    clear_caps();
    ticks(40);
    chk("post_rst_rinc", qsum(cap_rinc), 0);
    chk("post_rst_tx", qsum(cap_tx), 40);
    chk("post_rst_busy", qsum(cap_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
